load_store_unit: RTL and testbench

- Memory-access stage directly downstream of the ALU in the single-cycle CPU.
- Takes the ALU result as the effective address and the rs2 value as store data, then runs one load or store on a req/ack data bus.
- Supports byte, halfword and word accesses, with byte-lane steering and sign/zero extension.
- Holds `busy` high to stall PC/register-file writeback until the access completes, faults on misalignment, or times out.

---
 rtl/load_store_unit_if.sv | 33 +++
 rtl/load_store_unit.sv | 166 ++++++++++++++++
 tb/tb_load_store_unit.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Data-bus bundle between the load/store unit and memory.
// The LSU is the master; memory answers with rdata/ack.
interface load_store_unit_if #(
  parameter int WORD_SIZE = 32
);
  logic                 bus_req;
  logic                 bus_we;
  logic [WORD_SIZE-1:0] bus_addr;
  logic [3:0]           bus_be;
  logic [WORD_SIZE-1:0] bus_wdata;
  logic [WORD_SIZE-1:0] bus_rdata;
  logic                 bus_ack;

  modport master (
    output bus_req,
    output bus_we,
    output bus_addr,
    output bus_be,
    output bus_wdata,
    input  bus_rdata,
    input  bus_ack
  );

  modport slave (
    input  bus_req,
    input  bus_we,
    input  bus_addr,
    input  bus_be,
    input  bus_wdata,
    output bus_rdata,
    output bus_ack
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage: one byte/half/word load or store per start,
// with lane steering, load extension, misalign fault and bus timeout.
module load_store_unit #(
  parameter int WORD_SIZE = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [1:0]           size,
  input  logic                 sign_ext,
  input  logic [WORD_SIZE-1:0] addr,
  input  logic [WORD_SIZE-1:0] wdata,
  output logic                 busy,
  output logic                 done,
  output logic [WORD_SIZE-1:0] rdata,
  output logic                 misalign,
  output logic                 bus_err,
  load_store_unit_if.master    bus
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  state_t state, state_n;

  logic                 req_ok;
  logic                 legal;
  logic                 accept;
  logic                 fault;
  logic                 tmo;
  logic [7:0]           cnt;
  logic [1:0]           cap_off;
  logic [1:0]           cap_sz;
  logic                 cap_sx;
  logic [3:0]           be_n;
  logic [WORD_SIZE-1:0] wd_n;
  logic [WORD_SIZE-1:0] shifted;
  logic [WORD_SIZE-1:0] ext;

  assign req_ok = start & (mem_read ^ mem_write);

  always_comb begin
    legal = 1'b0;
    be_n  = '0;
    wd_n  = '0;
    unique case (1'b1)
      size == 2'b00: begin
        legal = 1'b1;
        be_n  = 4'b0001 << addr[1:0];
        wd_n  = {4{wdata[7:0]}};
      end
      size == 2'b01: begin
        legal = ~addr[0];
        be_n  = addr[1] ? 4'b1100 : 4'b0011;
        wd_n  = {2{wdata[15:0]}};
      end
      size == 2'b10: begin
        legal = (addr[1:0] == 2'b00);
        be_n  = 4'b1111;
        wd_n  = wdata;
      end
      default: ;
    endcase
  end

  // Bring the addressed lane down to bit 0 before extending.
  assign shifted = bus.bus_rdata >> {cap_off, 3'b000};

  always_comb begin
    ext = bus.bus_rdata;
    unique case (1'b1)
      cap_sz == 2'b00:
        ext = {{(WORD_SIZE-8){cap_sx & shifted[7]}},
               shifted[7:0]};
      cap_sz == 2'b01:
        ext = {{(WORD_SIZE-16){cap_sx & shifted[15]}},
               shifted[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    fault   = 1'b0;
    tmo     = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_ok) begin
          if (legal) begin
            accept  = 1'b1;
            state_n = REQ;
          end else begin
            fault = 1'b1;
          end
        end
      end
      REQ: begin
        // An ack on the last allowed cycle still completes.
        if (bus.bus_ack) begin
          state_n = DONE;
        end else if (cnt == 8'(TIMEOUT - 1)) begin
          tmo     = 1'b1;
          state_n = IDLE;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign      <= 1'b0;
      bus_err       <= 1'b0;
      rdata         <= '0;
      cnt           <= '0;
      cap_off       <= '0;
      cap_sz        <= '0;
      cap_sx        <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_be    <= '0;
      bus.bus_wdata <= '0;
    end else begin
      misalign <= fault;
      bus_err  <= tmo;
      if (accept) begin
        cap_off       <= addr[1:0];
        cap_sz        <= size;
        cap_sx        <= sign_ext;
        cnt           <= '0;
        bus.bus_we    <= mem_write;
        bus.bus_addr  <= {addr[WORD_SIZE-1:2], 2'b00};
        bus.bus_be    <= be_n;
        bus.bus_wdata <= wd_n;
      end else if (state == REQ) begin
        cnt <= cnt + 8'd1;
      end
      if (state == REQ && bus.bus_ack && !bus.bus_we) begin
        rdata <= ext;
      end
    end
  end

  assign bus.bus_req = (state == REQ);
  assign done        = (state == DONE);
  // DONE is excluded so the CPU advances on the done edge.
  assign busy        = (state == REQ) |
                       ((state == IDLE) & req_ok);

endmodule

// File: tb/tb_load_store_unit.sv
// Directed plus randomized bench for load_store_unit against a
// byte-level reference model of lanes, enables and extension.
module tb_load_store_unit;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sign_ext = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        busy, done, misalign, bus_err;
  logic [31:0] rdata;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] m_rdata = '0;

  load_store_unit_if #(.WORD_SIZE(32)) lsu_bus ();

  load_store_unit #(.WORD_SIZE(32), .TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .size     (size),
    .sign_ext (sign_ext),
    .addr     (addr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .rdata    (rdata),
    .misalign (misalign),
    .bus_err  (bus_err),
    .bus      (lsu_bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: an access touches n bytes starting at the byte offset.
  function automatic void ref_acc(
    input  logic [31:0] a,
    input  logic [1:0]  sz,
    input  logic        sx,
    input  logic [31:0] wd,
    input  logic [31:0] rb,
    output bit          legal,
    output logic [3:0]  be,
    output logic [31:0] bw,
    output logic [31:0] ld
  );
    int n;
    int off;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    off = int'(a[1:0]);
    legal = (sz != 2'd3) && ((off % n) == 0);
    be = '0;
    bw = '0;
    ld = '0;
    for (int i = 0; i < 4; i++) bw[8*i +: 8] = wd[8*(i % n) +: 8];
    if (legal) begin
      for (int i = 0; i < n; i++) begin
        be[off + i] = 1'b1;
        ld[8*i +: 8] = rb[8*(off + i) +: 8];
      end
      if (sx && n < 4 && ld[8*n - 1])
        for (int i = n; i < 4; i++) ld[8*i +: 8] = 8'hFF;
    end
  endfunction

  task automatic do_access(input bit we, input logic [31:0] a,
                           input logic [1:0] sz, input bit sx,
                           input logic [31:0] wd, input logic [31:0] rb,
                           input int d);
    bit          legal;
    logic [3:0]  be;
    logic [31:0] bw;
    logic [31:0] ld;
    ref_acc(a, sz, sx, wd, rb, legal, be, bw, ld);
    start = 1'b1;
    mem_read = !we;
    mem_write = we;
    addr = a;
    size = sz;
    sign_ext = sx;
    wdata = wd;
    #1;
    chk("busy_accept", 32'(busy), 32'd1);
    tick();
    start = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    #1;
    if (!legal) begin
      chk("misalign", 32'(misalign), 32'd1);
      chk("mis_req", 32'(lsu_bus.bus_req), 32'd0);
      chk("mis_done", 32'(done), 32'd0);
      chk("mis_busy", 32'(busy), 32'd0);
      chk("mis_rdata", rdata, m_rdata);
      tick();
      chk("mis_pulse", 32'(misalign), 32'd0);
      return;
    end
    chk("req", 32'(lsu_bus.bus_req), 32'd1);
    chk("req_busy", 32'(busy), 32'd1);
    chk("we", 32'(lsu_bus.bus_we), 32'(we));
    chk("addr", lsu_bus.bus_addr, {a[31:2], 2'b00});
    chk("be", 32'(lsu_bus.bus_be), 32'(be));
    if (we) chk("wdata", lsu_bus.bus_wdata, bw);
    repeat (d) tick();
    chk("req_hold", 32'(lsu_bus.bus_req), 32'd1);
    lsu_bus.bus_ack = 1'b1;
    lsu_bus.bus_rdata = rb;
    tick();
    lsu_bus.bus_ack = 1'b0;
    lsu_bus.bus_rdata = $urandom;
    #1;
    if (!we) m_rdata = ld;
    chk("done", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_req", 32'(lsu_bus.bus_req), 32'd0);
    chk("done_err", 32'(bus_err), 32'd0);
    chk("rdata", rdata, m_rdata);
    tick();
    chk("done_pulse", 32'(done), 32'd0);
  endtask

  initial begin
    int n;
    lsu_bus.bus_ack = 1'b0;
    lsu_bus.bus_rdata = '0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_req", 32'(lsu_bus.bus_req), 32'd0);
    chk("rst_mis", 32'(misalign), 32'd0);
    chk("rst_err", 32'(bus_err), 32'd0);
    #2;
    rst_n = 1'b1;
    tick();

    do_access(1'b0, 32'h100, 2'd2, 1'b0, 32'h0, 32'h1234_5678, 2);
    chk("word_rdata", rdata, 32'h1234_5678);
    do_access(1'b0, 32'h103, 2'd0, 1'b1, 32'h0, 32'h80AA_BBCC, 1);
    chk("byte_sx", rdata, 32'hFFFF_FF80);
    do_access(1'b0, 32'h103, 2'd0, 1'b0, 32'h0, 32'h80AA_BBCC, 0);
    chk("byte_zx", rdata, 32'h0000_0080);
    do_access(1'b1, 32'h102, 2'd1, 1'b0, 32'h0000_ABCD, 32'h0, 0);
    chk("store_keeps_rdata", rdata, 32'h0000_0080);
    do_access(1'b0, 32'h101, 2'd2, 1'b0, 32'h0, 32'h0, 0);
    do_access(1'b0, 32'h103, 2'd1, 1'b0, 32'h0, 32'h0, 0);
    do_access(1'b0, 32'h100, 2'd3, 1'b0, 32'h0, 32'h0, 0);
    do_access(1'b0, 32'h202, 2'd1, 1'b1, 32'h0, 32'h8001_7FFF, 1);

    // Both read and write: request ignored.
    start = 1'b1;
    mem_read = 1'b1;
    mem_write = 1'b1;
    #1;
    chk("both_busy", 32'(busy), 32'd0);
    tick();
    start = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    #1;
    chk("both_req", 32'(lsu_bus.bus_req), 32'd0);
    chk("both_mis", 32'(misalign), 32'd0);

    // Timeout with no ack.
    start = 1'b1;
    mem_read = 1'b1;
    addr = 32'h300;
    size = 2'd2;
    tick();
    start = 1'b0;
    mem_read = 1'b0;
    #1;
    n = 0;
    while (lsu_bus.bus_req && n < 20) begin
      n++;
      tick();
    end
    chk("tmo_len", 32'(n), 32'(TO));
    chk("tmo_err", 32'(bus_err), 32'd1);
    chk("tmo_done", 32'(done), 32'd0);
    chk("tmo_rdata", rdata, m_rdata);
    tick();
    chk("tmo_pulse", 32'(bus_err), 32'd0);

    // Ack on the final timeout cycle completes normally.
    do_access(1'b0, 32'h304, 2'd2, 1'b0, 32'h0, 32'hCAFE_F00D, TO - 1);

    // Stray ack while idle.
    lsu_bus.bus_ack = 1'b1;
    lsu_bus.bus_rdata = 32'hDEAD_BEEF;
    tick();
    lsu_bus.bus_ack = 1'b0;
    #1;
    chk("stray_done", 32'(done), 32'd0);
    chk("stray_req", 32'(lsu_bus.bus_req), 32'd0);
    chk("stray_rdata", rdata, m_rdata);

    for (int i = 0; i < 40; i++) begin
      do_access(1'($urandom % 2), $urandom, 2'($urandom % 4),
                1'($urandom % 2), $urandom, $urandom,
                int'($urandom % TO));
    end

    // Reset in the middle of a request.
    start = 1'b1;
    mem_read = 1'b1;
    addr = 32'h400;
    size = 2'd2;
    tick();
    start = 1'b0;
    mem_read = 1'b0;
    #1;
    chk("mid_req", 32'(lsu_bus.bus_req), 32'd1);
    rst_n = 1'b0;
    #1;
    m_rdata = '0;
    chk("mid_rst_req", 32'(lsu_bus.bus_req), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_rdata", rdata, m_rdata);
    #2;
    rst_n = 1'b1;
    lsu_bus.bus_ack = 1'b1;
    tick();
    lsu_bus.bus_ack = 1'b0;
    repeat (3) begin
      chk("mid_rst_nodone", 32'(done), 32'd0);
      tick();
    end
    do_access(1'b0, 32'h404, 2'd0, 1'b1, 32'h0, 32'h0000_7F00, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
